// File: rtl/acc_seq_pkg.sv
// acc_seq_pkg: shared opcodes, ALU encodings, FSM state type and the
// decoded-control record used by the accumulator instruction sequencer.
package acc_seq_pkg;

   localparam logic [3:0] OP_NOP  = 4'h0;
   localparam logic [3:0] OP_LDI  = 4'h1;
   localparam logic [3:0] OP_LDR  = 4'h2;
   localparam logic [3:0] OP_STR  = 4'h3;
   localparam logic [3:0] OP_ADD  = 4'h4;
   localparam logic [3:0] OP_SUB  = 4'h5;
   localparam logic [3:0] OP_AND  = 4'h6;
   localparam logic [3:0] OP_OR   = 4'h7;
   localparam logic [3:0] OP_XOR  = 4'h8;
   localparam logic [3:0] OP_SKZ  = 4'h9;
   localparam logic [3:0] OP_HALT = 4'hF;

   localparam logic [2:0] ALU_ADD = 3'd0;
   localparam logic [2:0] ALU_SUB = 3'd1;
   localparam logic [2:0] ALU_AND = 3'd2;
   localparam logic [2:0] ALU_OR  = 3'd3;
   localparam logic [2:0] ALU_XOR = 3'd4;

   typedef enum logic [1:0] {
      ST_FETCH  = 2'd0,
      ST_DECODE = 2'd1,
      ST_EXEC   = 2'd2,
      ST_HALT   = 2'd3
   } state_t;

   typedef struct packed {
      logic       sel0;
      logic       sel1;
      logic       load;
      logic       we;
      logic [2:0] alu_op;
      logic       illegal;
   } ctrl_t;

endpackage

// File: rtl/acc_seq_decode.sv
// acc_seq_decode: purely combinational opcode to datapath-control decoder.
// Opcode 9 (SKZ) is legal only when ACC_SEQ_SKIPZ_EN is defined; it drives
// no datapath control of its own, the top level handles the skip flag.
module acc_seq_decode
   import acc_seq_pkg::*;
#(
   parameter int OPW = 4
) (
   input  logic [OPW-1:0] opcode,
   output ctrl_t          ctrl
);

   // Map each opcode to its selects, strobes and ALU function; unknown opcodes flag illegal.
   always_comb begin
      ctrl = '0;
      case (opcode)
         OP_NOP, OP_HALT: begin
         end
         OP_LDI: begin
            ctrl.sel0 = 1'b1;
            ctrl.sel1 = 1'b1;
            ctrl.load = 1'b1;
         end
         OP_LDR: begin
            ctrl.sel1 = 1'b1;
            ctrl.load = 1'b1;
         end
         OP_STR: begin
            ctrl.we = 1'b1;
         end
         OP_ADD: begin
            ctrl.load   = 1'b1;
            ctrl.alu_op = ALU_ADD;
         end
         OP_SUB: begin
            ctrl.load   = 1'b1;
            ctrl.alu_op = ALU_SUB;
         end
         OP_AND: begin
            ctrl.load   = 1'b1;
            ctrl.alu_op = ALU_AND;
         end
         OP_OR: begin
            ctrl.load   = 1'b1;
            ctrl.alu_op = ALU_OR;
         end
         OP_XOR: begin
            ctrl.load   = 1'b1;
            ctrl.alu_op = ALU_XOR;
         end
`ifdef ACC_SEQ_SKIPZ_EN
         OP_SKZ: begin
         end
`endif
         default: begin
            ctrl.illegal = 1'b1;
         end
      endcase
   end

endmodule

// File: rtl/acc_seq.sv
// acc_seq: three-cycle FETCH/DECODE/EXEC instruction sequencer driving the
// accumulator datapath controls. Optional feature macro ACC_SEQ_SKIPZ_EN
// enables the SKZ (skip next instruction if accumulator is zero) opcode.
module acc_seq
   import acc_seq_pkg::*;
#(
   parameter int OPW  = 4,
   parameter int CNTW = 8
) (
   input  logic            clk,
   input  logic            clb,
   input  logic            instr_valid,
   input  logic [7:0]      instr,
   output logic            instr_ready,
   input  logic            acc_zero,
   output logic            sel_acc0,
   output logic            sel_acc1,
   output logic            load_acc,
   output logic [2:0]      alu_op,
   output logic [3:0]      reg_addr,
   output logic            reg_we,
   output logic [3:0]      imm,
   output logic            halted,
   output logic            illegal,
   output logic [CNTW-1:0] retired
);

   state_t         state;
   logic [7:0]     ir;
   logic [OPW-1:0] opcode;
   ctrl_t          ctrl;
   logic           skip;
   logic           is_halt;

   assign opcode  = ir[7 -: OPW];
   assign is_halt = (opcode == OP_HALT);

   acc_seq_decode #(
      .OPW (OPW)
   ) u_decode (
      .opcode (opcode),
      .ctrl   (ctrl)
   );

`ifdef ACC_SEQ_SKIPZ_EN
   // Arm the skip flag on a taken SKZ; the next instruction's EXEC consumes it.
   always_ff @(posedge clk or negedge clb) begin
      if (!clb) begin
         skip <= 1'b0;
      end else if (state == ST_EXEC) begin
         if (skip) begin
            skip <= 1'b0;
         end else if (opcode == OP_SKZ && acc_zero) begin
            skip <= 1'b1;
         end
      end
   end
`else
   logic unused_acc_zero;
   assign skip            = 1'b0;
   assign unused_acc_zero = acc_zero;
`endif

   // Sequencer FSM with instruction register and retired-instruction counter.
   always_ff @(posedge clk or negedge clb) begin
      if (!clb) begin
         state   <= ST_FETCH;
         ir      <= '0;
         retired <= '0;
      end else begin
         case (state)
            ST_FETCH: begin
               if (instr_valid) begin
                  ir    <= instr;
                  state <= ST_DECODE;
               end
            end
            ST_DECODE: begin
               state <= ST_EXEC;
            end
            ST_EXEC: begin
               if (!skip) begin
                  retired <= retired + CNTW'(1);
               end
               state <= (is_halt && !skip) ? ST_HALT : ST_FETCH;
            end
            default: begin
               state <= ST_HALT;
            end
         endcase
      end
   end

   // Controls are held steady through DECODE and EXEC; strobes fire only in EXEC of a non-skipped instruction.
   always_comb begin
      instr_ready = (state == ST_FETCH);
      halted      = (state == ST_HALT);
      sel_acc0    = 1'b0;
      sel_acc1    = 1'b0;
      alu_op      = '0;
      reg_addr    = '0;
      imm         = '0;
      load_acc    = 1'b0;
      reg_we      = 1'b0;
      illegal     = 1'b0;
      if (state == ST_DECODE || state == ST_EXEC) begin
         sel_acc0 = ctrl.sel0;
         sel_acc1 = ctrl.sel1;
         alu_op   = ctrl.alu_op;
         reg_addr = ir[3:0];
         imm      = ir[3:0];
      end
      if (state == ST_EXEC && !skip) begin
         load_acc = ctrl.load;
         reg_we   = ctrl.we;
         illegal  = ctrl.illegal;
      end
   end

endmodule

// File: tb/tb_acc_seq.sv
// tb_acc_seq: table-driven, randomized and hand-sequenced checks of acc_seq
// against a small opcode-rule reference model.
module tb_acc_seq;

`ifdef ACC_SEQ_SKIPZ_EN
   localparam bit SKZ_EN = 1'b1;
`else
   localparam bit SKZ_EN = 1'b0;
`endif

   logic       clk = 1'b0;
   logic       clb = 1'b0;
   logic       instr_valid = 1'b0;
   logic [7:0] instr = 8'h00;
   logic       acc_zero = 1'b0;
   logic       instr_ready;
   logic       sel_acc0;
   logic       sel_acc1;
   logic       load_acc;
   logic [2:0] alu_op;
   logic [3:0] reg_addr;
   logic       reg_we;
   logic [3:0] imm;
   logic       halted;
   logic       illegal;
   logic [7:0] retired;

   int checks = 0;
   int failures = 0;
   int exp_retired = 0;
   bit skip_pending = 1'b0;

   typedef struct {
      logic [7:0] ins;
      logic       load;
      logic       we;
      logic       ill;
      logic       s0;
      logic       s1;
      logic [2:0] alu;
   } vec_t;

   vec_t vecs[12];

   acc_seq #(
      .OPW  (4),
      .CNTW (8)
   ) dut (
      .clk         (clk),
      .clb         (clb),
      .instr_valid (instr_valid),
      .instr       (instr),
      .instr_ready (instr_ready),
      .acc_zero    (acc_zero),
      .sel_acc0    (sel_acc0),
      .sel_acc1    (sel_acc1),
      .load_acc    (load_acc),
      .alu_op      (alu_op),
      .reg_addr    (reg_addr),
      .reg_we      (reg_we),
      .imm         (imm),
      .halted      (halted),
      .illegal     (illegal),
      .retired     (retired)
   );

   always #5 clk = ~clk;

   task automatic check_output(input string name, input logic [31:0] actual, input logic [31:0] expected);
      checks++;
      if (actual !== expected) begin
         failures++;
         $display("[TB] FAIL %s: got %0h expected %0h", name, actual, expected);
      end
   endtask

   // Expected controls straight from the opcode table.
   function automatic void ref_model(input logic [7:0] ins, output logic load, output logic we,
                                     output logic ill, output logic s0, output logic s1,
                                     output logic [2:0] alu);
      int op;
      op   = int'(ins[7:4]);
      load = (op == 1 || op == 2 || (op >= 4 && op <= 8));
      we   = (op == 3);
      s0   = (op == 1);
      s1   = (op == 1 || op == 2);
      alu  = (op >= 4 && op <= 8) ? 3'(op - 4) : 3'd0;
      ill  = !(op <= 8 || op == 15 || (SKZ_EN && op == 9));
   endfunction

   task automatic wait_ready();
      int n = 0;
      while (!instr_ready && n < 10) begin
         @(negedge clk);
         n++;
      end
      check_output("fetch_ready", {31'd0, instr_ready}, 32'd1);
   endtask

   // Issue one instruction and check DECODE, EXEC and the following cycle.
   task automatic apply_stimulus(input logic [7:0] ins, input logic e_load, input logic e_we,
                                 input logic e_ill, input logic e_s0, input logic e_s1,
                                 input logic [2:0] e_alu);
      bit skipped;
      bit is_halt;
      skipped = skip_pending;
      wait_ready();
      instr_valid = 1'b1;
      instr       = ins;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      instr       = 8'($urandom);
      check_output("dec_ready", {31'd0, instr_ready}, 32'd0);
      check_output("dec_load", {31'd0, load_acc}, 32'd0);
      check_output("dec_we", {31'd0, reg_we}, 32'd0);
      check_output("dec_ill", {31'd0, illegal}, 32'd0);
      check_output("dec_addr", {28'd0, reg_addr}, {28'd0, ins[3:0]});
      check_output("dec_imm", {28'd0, imm}, {28'd0, ins[3:0]});
      if (!skipped) begin
         check_output("dec_sel0", {31'd0, sel_acc0}, {31'd0, e_s0});
         check_output("dec_sel1", {31'd0, sel_acc1}, {31'd0, e_s1});
         check_output("dec_alu", {29'd0, alu_op}, {29'd0, e_alu});
      end
      @(negedge clk);
      check_output("exec_load", {31'd0, load_acc}, {31'd0, e_load && !skipped});
      check_output("exec_we", {31'd0, reg_we}, {31'd0, e_we && !skipped});
      check_output("exec_ill", {31'd0, illegal}, {31'd0, e_ill && !skipped});
      check_output("exec_addr", {28'd0, reg_addr}, {28'd0, ins[3:0]});
      check_output("exec_imm", {28'd0, imm}, {28'd0, ins[3:0]});
      if (!skipped) begin
         check_output("exec_sel0", {31'd0, sel_acc0}, {31'd0, e_s0});
         check_output("exec_sel1", {31'd0, sel_acc1}, {31'd0, e_s1});
         check_output("exec_alu", {29'd0, alu_op}, {29'd0, e_alu});
         exp_retired = (exp_retired + 1) % 256;
      end
      is_halt = (ins[7:4] == 4'hF) && !skipped;
      if (skipped) begin
         skip_pending = 1'b0;
      end else if (SKZ_EN && ins[7:4] == 4'h9 && acc_zero) begin
         skip_pending = 1'b1;
      end
      @(negedge clk);
      check_output("post_retired", {24'd0, retired}, 32'(exp_retired));
      check_output("post_halted", {31'd0, halted}, {31'd0, is_halt});
      check_output("post_ready", {31'd0, instr_ready}, {31'd0, !is_halt});
      check_output("post_load", {31'd0, load_acc}, 32'd0);
   endtask

   task automatic apply_modelled(input logic [7:0] ins);
      logic l, w, il, s0, s1;
      logic [2:0] a;
      ref_model(ins, l, w, il, s0, s1, a);
      apply_stimulus(ins, l, w, il, s0, s1, a);
   endtask

   task automatic do_reset();
      @(negedge clk);
      clb = 1'b0;
      #1;
      check_output("rst_load", {31'd0, load_acc}, 32'd0);
      check_output("rst_halted", {31'd0, halted}, 32'd0);
      check_output("rst_retired", {24'd0, retired}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      clb = 1'b1;
      exp_retired  = 0;
      skip_pending = 1'b0;
      #1;
      check_output("rst_ready", {31'd0, instr_ready}, 32'd1);
   endtask

   initial begin
      int ready_count;
      bit seen_load;
      int r0;

      vecs[0]  = '{8'h15, 1'b1, 1'b0, 1'b0, 1'b1, 1'b1, 3'd0};
      vecs[1]  = '{8'h23, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 3'd0};
      vecs[2]  = '{8'h47, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
      vecs[3]  = '{8'h32, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 3'd0};
      vecs[4]  = '{8'h5A, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd1};
      vecs[5]  = '{8'h6B, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd2};
      vecs[6]  = '{8'h7C, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd3};
      vecs[7]  = '{8'h8D, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 3'd4};
      vecs[8]  = '{8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0};
      vecs[9]  = '{8'hA0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
      vecs[10] = '{8'hB3, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 3'd0};
      vecs[11] = '{8'h9F, 1'b0, 1'b0, !SKZ_EN, 1'b0, 1'b0, 3'd0};

      do_reset();

      for (int i = 0; i < 12; i++) begin
         apply_stimulus(vecs[i].ins, vecs[i].load, vecs[i].we, vecs[i].ill,
                        vecs[i].s0, vecs[i].s1, vecs[i].alu);
      end

      for (int i = 0; i < 40; i++) begin
         apply_modelled({4'($urandom_range(0, 14)), 4'($urandom)});
      end

      // Held valid: LDR R3 then ADD R7, ready only one cycle in three.
      wait_ready();
      instr_valid = 1'b1;
      instr       = 8'h23;
      ready_count = 0;
      for (int c = 0; c < 6; c++) begin
         if (instr_ready) ready_count++;
         if (c == 1) instr = 8'h47;
         if (c == 5) begin
            check_output("add_sel1", {31'd0, sel_acc1}, 32'd0);
            check_output("add_alu", {29'd0, alu_op}, 32'd0);
            check_output("add_addr", {28'd0, reg_addr}, 32'd7);
            check_output("add_load", {31'd0, load_acc}, 32'd1);
         end
         @(negedge clk);
      end
      instr_valid = 1'b0;
      exp_retired = (exp_retired + 2) % 256;
      check_output("held_ready_count", 32'(ready_count), 32'd2);
      check_output("held_retired", {24'd0, retired}, 32'(exp_retired));

      // HALT then 20 cycles parked with valid asserted.
      apply_stimulus(8'hF0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      instr_valid = 1'b1;
      instr       = 8'h15;
      for (int c = 0; c < 20; c++) begin
         @(negedge clk);
         check_output("halt_ready", {31'd0, instr_ready}, 32'd0);
         check_output("halt_halted", {31'd0, halted}, 32'd1);
      end
      instr_valid = 1'b0;
      check_output("halt_retired", {24'd0, retired}, 32'(exp_retired));

      do_reset();

      // Reset asserted during EXEC of SUB RA aborts the strobe.
      wait_ready();
      instr_valid = 1'b1;
      instr       = 8'h5A;
      @(posedge clk);
      @(negedge clk);
      instr_valid = 1'b0;
      @(negedge clk);
      check_output("abort_pre_load", {31'd0, load_acc}, 32'd1);
      #2;
      clb = 1'b0;
      #1;
      check_output("abort_load", {31'd0, load_acc}, 32'd0);
      check_output("abort_alu", {29'd0, alu_op}, 32'd0);
      check_output("abort_addr", {28'd0, reg_addr}, 32'd0);
      check_output("abort_imm", {28'd0, imm}, 32'd0);
      seen_load = 1'b0;
      for (int c = 0; c < 3; c++) begin
         @(negedge clk);
         if (load_acc) seen_load = 1'b1;
      end
      check_output("abort_no_load", {31'd0, seen_load}, 32'd0);
      clb = 1'b1;
      exp_retired  = 0;
      skip_pending = 1'b0;
      #1;
      check_output("abort_ready", {31'd0, instr_ready}, 32'd1);
      check_output("abort_retired", {24'd0, retired}, 32'd0);

      // 256 NOPs wrap the counter back to zero.
      for (int i = 0; i < 256; i++) begin
         apply_stimulus(8'h00, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 3'd0);
      end
      check_output("wrap_retired", {24'd0, retired}, 32'd0);

`ifdef ACC_SEQ_SKIPZ_EN
      // SKZ with accumulator zero skips the following LDI.
      acc_zero = 1'b1;
      r0 = exp_retired;
      apply_modelled(8'h90);
      apply_modelled(8'h19);
      apply_modelled(8'h13);
      check_output("skz_retired", {24'd0, retired}, 32'((r0 + 2) % 256));
      apply_modelled(8'h90);
      apply_modelled(8'hF0);
      check_output("skz_halt_skipped", {31'd0, halted}, 32'd0);
      acc_zero = 1'b0;
`else
      r0 = exp_retired;
      acc_zero = 1'b1;
      apply_modelled(8'h90);
      apply_modelled(8'h13);
      check_output("noskz_retired", {24'd0, retired}, 32'((r0 + 2) % 256));
      acc_zero = 1'b0;
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/acc_seq.md
# acc_seq

Multi-cycle instruction sequencer for the 8-bit accumulator datapath. It accepts one 8-bit instruction at a time over a valid/ready handshake, decodes it, and drives the accumulator datapath controls: the mux selects, the accumulator load strobe, the ALU opcode and the register-file address and write enable. It sits between instruction memory and the accumulator/mux/ALU/register-file datapath, and is the only source of those control strobes.

## Interface
Parameters:
- `OPW`, 4: opcode width, `instr[7:4]`.
- `CNTW`, 8: width of the retired-instruction counter.

Ports:
- `clk`  in  1  the single clock; rising edge.
- `clb`  in  1  reset; asynchronous, active-low.
- `instr_valid`  in  1  an instruction is present on `instr`.
- `instr`  in  8  `[7:4]` opcode, `[3:0]` operand (immediate or register number).
- `instr_ready`  out  1  sequencer can accept an instruction.
- `acc_zero`  in  1  accumulator equals 0; used only with `ACC_SEQ_SKIPZ_EN`.
- `sel_acc0`  out  1  MUX0 select: 1 = immediate, 0 = register data.
- `sel_acc1`  out  1  MUX1 select: 1 = MUX0 path, 0 = ALU result.
- `load_acc`  out  1  accumulator load strobe, one cycle.
- `alu_op`  out  3  ALU function: 0 ADD, 1 SUB, 2 AND, 3 OR, 4 XOR.
- `reg_addr`  out  4  register-file read/write address.
- `reg_we`  out  1  register-file write strobe (writes accumulator), one cycle.
- `imm`  out  4  immediate to MUX0.
- `halted`  out  1  HALT executed.
- `illegal`  out  1  one-cycle pulse on an undefined opcode.
- `retired`  out  CNTW  count of completed instructions; wraps.

## Operation
- Opcodes: 0 NOP; 1 LDI (acc←imm); 2 LDR (acc←R[n]); 3 STR (R[n]←acc); 4 ADD; 5 SUB; 6 AND; 7 OR; 8 XOR (acc←acc op R[n]); 9 SKZ (only when the macro is defined); F HALT. All others are illegal.
- FSM states: FETCH, DECODE, EXEC, HALT.
  - FETCH: `instr_ready`=1. On `instr_valid`&&`instr_ready`, latch the IR and go to DECODE.
  - DECODE: drive `reg_addr`, `imm`, `alu_op`, `sel_acc0` and `sel_acc1` from the IR. Go to EXEC.
  - EXEC: hold all DECODE outputs. Pulse `load_acc` (LDI/LDR/ALU ops), `reg_we` (STR) or `illegal`. Increment `retired`. Go to FETCH, or to HALT on HALT.
  - HALT: `halted`=1 and `instr_ready`=0 until reset.
- Select encoding:
  - LDI: sel0=1, sel1=1.
  - LDR: sel0=0, sel1=1.
  - ALU ops: sel1=0, sel0=0.
  - All others: both selects 0.
- An illegal opcode behaves as NOP, pulses `illegal` in EXEC and still retires.
- NOP, HALT and illegal opcodes assert neither `load_acc` nor `reg_we`.
- `retired` wraps from 2^CNTW−1 to 0. HALT counts as retired.

## Timing
- Reset values (asynchronous on `clb`=0): state FETCH; IR=0; `instr_ready`=1 after reset release; every other output 0; `retired`=0.
- Handshake: transfer on the rising edge where valid&&ready. `instr_ready` is 0 in DECODE, EXEC and HALT, so instructions are never back-to-back.
- Latency: handshake edge at cycle 0 → DECODE in cycle 1 → EXEC in cycle 2 (strobes high) → FETCH in cycle 3. Throughput is one instruction per 3 cycles with `instr_valid` held high.
- Selects, `alu_op` and `reg_addr` are stable through DECODE and EXEC, so they are settled one full cycle before the strobe edge.
- Reset mid-instruction aborts the instruction. No strobe is emitted after `clb` falls.
- `instr_valid` deasserting while `instr_ready`=0 has no effect.

## Configuration
- `ACC_SEQ_SKIPZ_EN` defined: opcode 9 SKZ is legal.
  - In EXEC, if `acc_zero`=1, set a skip flag.
  - The next accepted instruction passes through DECODE/EXEC with no strobes and no `illegal` pulse, and is not counted in `retired`.
  - The flag clears after that instruction.
  - A skipped HALT does not halt.
- Macro undefined: opcode 9 is illegal, `acc_zero` is ignored, and no skip flag exists.

## Structure
- Package `acc_seq_pkg` holds:
  - opcode localparams (`OP_NOP`…`OP_HALT`, `OP_SKZ`);
  - the ALU op encodings;
  - the state enum typedef;
  - the decoded-control struct typedef (sel0, sel1, load, we, alu_op, illegal).
- Sub-module `acc_seq_decode` is a purely combinational opcode-to-control-struct decoder. The top level holds the FSM, IR, skip flag and counter.

## Test plan
- Reset, then LDI 0x5 (`instr`=8'h15): `load_acc`=1 with sel0=1, sel1=1, `imm`=4'h5 exactly 2 cycles after the handshake edge; `retired`=1.
- LDR R3 (8'h23) then ADD R7 (8'h47) with `instr_valid` held: `instr_ready` high one cycle in three; ADD EXEC shows sel1=0, `alu_op`=0, `reg_addr`=7.
- STR R2 (8'h32): `reg_we`=1 for one cycle, `reg_addr`=2, `load_acc`=0.
- Opcode 8'hA0: `illegal` pulses once, no strobes, `retired` increments. Then 8'hF0: `halted`=1, `instr_ready` stays 0 for 20 cycles.
- Assert `clb`=0 during EXEC of ADD: outputs zero immediately, no `load_acc` pulse; after release `instr_ready`=1. Separately, 256 NOPs: `retired` returns to 0.
- With the macro defined: `acc_zero`=1, SKZ (8'h90) then LDI 0x9 then LDI 0x3: only the second LDI loads (`imm`=3), and `retired` increases by 2.
